// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, command-field widths and FIFO entry layout for the ALU sequencer
package alu_pkg;

    localparam int OPCODE_W  = 3;
    localparam int USE_ACC_W = 1;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_SHLA = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_SHLB = 3'b111;

    // Entry layout, LSB first: use_acc, B, A, opcode.
    function automatic int entry_w(input int w);
        return OPCODE_W + 2 * w + USE_ACC_W;
    endfunction

    function automatic int b_lsb(input int w);
        return USE_ACC_W;
    endfunction

    function automatic int a_lsb(input int w);
        return USE_ACC_W + w;
    endfunction

    function automatic int op_lsb(input int w);
        return USE_ACC_W + 2 * w;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, carry and compare flag per opcode
module alu_core
    import alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0]    a,
    input  logic [width-1:0]    b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [width-1:0]    result,
    output logic                carry,
    output logic                cmp
);

    logic [width:0] sum;
    logic [width:0] diff;

    // Subtraction as A + ~B + 1 so carry out reads as "no borrow".
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{width{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        cmp    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[width-1:0];
                carry  = sum[width];
            end
            OP_SUB: begin
                result = diff[width-1:0];
                carry  = diff[width];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_CMP: cmp = (a > b);
            OP_SHLA: begin
                result = {a[width-2:0], 1'b0};
                carry  = a[width-1];
            end
            OP_SHLB: begin
                result = {b[width-2:0], 1'b0};
                carry  = b[width-1];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO, issue logic, accumulator and registered ALU result
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int width = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OPCODE_W-1:0]        cmd_opcode,
    input  logic [width-1:0]           cmd_A,
    input  logic [width-1:0]           cmd_B,
    input  logic                       cmd_use_acc,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [width-1:0]           ALU_OUT,
    output logic                       Cout,
    output logic                       C_Flag,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_w(width);

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [width-1:0]    acc;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic [OPCODE_W-1:0] head_op;
    logic [width-1:0]    head_a;
    logic [width-1:0]    head_b;
    logic                head_use_acc;
    logic [width-1:0]    eff_a;
    logic [width-1:0]    core_result;
    logic                core_carry;
    logic                core_cmp;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = !empty && (!res_valid || res_ready);

    assign head         = mem[rd_ptr];
    assign head_use_acc = head[0];
    assign head_b       = head[b_lsb(width) +: width];
    assign head_a       = head[a_lsb(width) +: width];
    assign head_op      = head[op_lsb(width) +: OPCODE_W];

    // acc is read at issue time, so a chained command sees the result issued one edge earlier.
    assign eff_a = head_use_acc ? acc : head_a;

    alu_core #(.width(width)) u_core (
        .a      (eff_a),
        .b      (head_b),
        .opcode (head_op),
        .result (core_result),
        .carry  (core_carry),
        .cmp    (core_cmp)
    );

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_opcode, cmd_A, cmd_B, cmd_use_acc};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_valid <= 1'b0;
            ALU_OUT   <= '0;
            Cout      <= 1'b0;
            C_Flag    <= 1'b0;
            acc       <= '0;
        end else if (pop) begin
            res_valid <= 1'b1;
            ALU_OUT   <= core_result;
            Cout      <= core_carry;
            C_Flag    <= core_cmp;
            acc       <= core_result;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_A;
    logic [7:0] cmd_B;
    logic       cmd_use_acc;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] ALU_OUT;
    logic       Cout;
    logic       C_Flag;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.width(8), .DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_A       (cmd_A),
        .cmd_B       (cmd_B),
        .cmd_use_acc (cmd_use_acc),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .ALU_OUT     (ALU_OUT),
        .Cout        (Cout),
        .C_Flag      (C_Flag),
        .level       (level)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_A       = a;
        cmd_B       = b;
        cmd_use_acc = ua;
    endtask

    initial begin
        int  got;
        bit  acc5;
        RST = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_A = '0; cmd_B = '0; cmd_use_acc = 1'b0;
        res_ready = 1'b1;
        #12;
        check("rst_res_valid", res_valid, 0);
        check("rst_alu_out", ALU_OUT, 0);
        check("rst_level", level, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_flags", {Cout, C_Flag}, 0);
        @(negedge CLK);
        RST = 1'b1;
        step();

        // ADD with carry, single-cycle latency after accept
        drive(3'b000, 8'hF0, 8'h20, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("add_not_yet", res_valid, 0);
        check("add_level1", level, 1);
        step();
        check("add_valid", res_valid, 1);
        check("add_out", ALU_OUT, 8'h10);
        check("add_cout", Cout, 1);
        check("add_cflag", C_Flag, 0);
        step();
        check("add_cleared", res_valid, 0);

        // back-to-back SUB
        drive(3'b001, 8'h05, 8'h07, 1'b0);
        step();
        drive(3'b001, 8'h07, 8'h05, 1'b0);
        step();
        check("sub1_out", ALU_OUT, 8'hFE);
        check("sub1_cout", Cout, 0);
        cmd_valid = 1'b0;
        step();
        check("sub2_valid", res_valid, 1);
        check("sub2_out", ALU_OUT, 8'h02);
        check("sub2_cout", Cout, 1);
        step();

        // CMP, CMP equal, SHLA
        drive(3'b101, 8'h80, 8'h7F, 1'b0);
        step();
        drive(3'b101, 8'h33, 8'h33, 1'b0);
        step();
        check("cmp_gt_out", ALU_OUT, 8'h00);
        check("cmp_gt_flag", C_Flag, 1);
        drive(3'b110, 8'h81, 8'h00, 1'b0);
        step();
        check("cmp_eq_flag", C_Flag, 0);
        check("cmp_eq_out", ALU_OUT, 8'h00);
        cmd_valid = 1'b0;
        step();
        check("shla_out", ALU_OUT, 8'h02);
        check("shla_cout", Cout, 1);
        check("shla_cflag", C_Flag, 0);
        step();

        // backpressure: 6 commands, only 5 fit
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(3'b000, 8'(i), 8'h10, 1'b0);
            step();
        end
        drive(3'b000, 8'h05, 8'h10, 1'b0);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_level", level, 4);
        check("bp_res_valid", res_valid, 1);
        check("bp_head_out", ALU_OUT, 8'h10);
        step();
        step();
        check("bp_hold_level", level, 4);
        check("bp_hold_out", ALU_OUT, 8'h10);
        check("bp_hold_valid", res_valid, 1);
        got  = 0;
        acc5 = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            res_ready = cyc[0];
            if (res_valid && res_ready) begin
                check($sformatf("bp_order%0d", got), ALU_OUT, 8'h10 + got);
                got++;
            end
            if (cmd_valid && cmd_ready) acc5 = 1'b1;
            step();
            if (acc5) cmd_valid = 1'b0;
        end
        check("bp_count", got, 6);
        check("bp_sixth_accepted", acc5, 1);
        res_ready = 1'b1;
        step();
        check("bp_drained_valid", res_valid, 0);
        check("bp_drained_level", level, 0);

        // accumulator chain with no gap cycles
        drive(3'b000, 8'h01, 8'h02, 1'b0);
        step();
        drive(3'b000, 8'hFF, 8'h04, 1'b1);
        step();
        check("chain1_out", ALU_OUT, 8'h03);
        drive(3'b110, 8'h00, 8'h00, 1'b1);
        step();
        check("chain2_out", ALU_OUT, 8'h07);
        cmd_valid = 1'b0;
        step();
        check("chain3_out", ALU_OUT, 8'h0E);
        check("chain3_cout", Cout, 0);
        step();

        // reset mid-operation
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, 8'h0F, 8'(8'h30 + i), 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        check("mid_level", level, 3);
        check("mid_valid", res_valid, 1);
        check("mid_out", ALU_OUT, 8'h3F);
        #2;
        RST = 1'b0;
        #1;
        check("mrst_out", ALU_OUT, 0);
        check("mrst_valid", res_valid, 0);
        check("mrst_level", level, 0);
        check("mrst_flags", {Cout, C_Flag}, 0);
        check("mrst_ready", cmd_ready, 1);
        @(negedge CLK);
        RST = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_valid%0d", i), res_valid, 0);
            check($sformatf("post_level%0d", i), level, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front end for the datapath ALU. It accepts ALU commands (opcode plus two operands) over a valid/ready channel, buffers them in a small FIFO, and executes one per cycle on an internal combinational ALU core. It registers each result with its flags and returns it over a valid/ready result channel. An accumulator lets chained commands use the previous result as operand A.

## Interface
- `width`, 8, operand/result width in bits
- `DEPTH`, 4, command FIFO depth; power of two, ≥2
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  FIFO can accept (`!full`)
- `cmd_opcode`  in  3  operation code, per table in Operation
- `cmd_A`  in  `width`  operand A
- `cmd_B`  in  `width`  operand B
- `cmd_use_acc`  in  1  replace A with accumulator at execute time
- `res_valid`  out  1  result register holds an unconsumed result
- `res_ready`  in  1  consumer takes result
- `ALU_OUT`  out  `width`  registered result
- `Cout`  out  1  registered carry flag
- `C_Flag`  out  1  registered compare flag
- `level`  out  `$clog2(DEPTH)+1`  FIFO occupancy, 0..DEPTH

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {opcode, A, B, use_acc} to the FIFO tail.
- Issue condition: `!empty && (!res_valid || res_ready)`. On that edge, the FIFO head pops and the core result loads into ALU_OUT/Cout/C_Flag. res_valid is set. The same result loads into the accumulator.
- If res_ready=1 and empty, res_valid clears.
- Effective A = use_acc ? acc : A. Sampled at issue, so back-to-back chained commands see the immediately preceding result.
- Opcodes. All arithmetic is unsigned, modulo 2^width. Flags not listed are 0.
  - 000: A+B, Cout=carry out
  - 001: A−B via A+~B+1, Cout=carry out (1 = no borrow)
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: compare, ALU_OUT=0, C_Flag=(A>B)
  - 110: A<<1, Cout=A[width−1]
  - 111: B<<1, Cout=B[width−1]
- Full FIFO: cmd_ready=0, and push is ignored even if a pop occurs that edge. Simultaneous push and pop when not full: level unchanged.
- Empty FIFO: no issue; the result register holds its value.
- Pointers wrap modulo DEPTH. level tracks pushes minus pops exactly.
- Ordering: strict FIFO. No result is dropped or duplicated under any res_ready pattern.

## Timing
- Reset (async assert, sync-safe release): pointers, level, acc, res_valid, ALU_OUT, Cout and C_Flag are all 0. cmd_ready=1 after reset.
- Reset mid-operation discards all queued commands and any pending result. Nothing is emitted after release.
- Latency: command accepted at edge N into an empty FIFO with a free result register → res_valid=1 after edge N+1.
- Throughput: 1 command/cycle sustained when res_ready=1.
- ALU_OUT, flags and res_valid are stable while `res_valid && !res_ready`.
- Capacity under full backpressure: DEPTH in FIFO + 1 in the result register.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`OP_ADD`…`OP_SHLB`)
  - command-field widths
  - FIFO entry layout
- Sub-module `alu_core`: purely combinational, parameterized by width. Inputs are A, B and opcode; outputs are result, carry and compare flag per the opcode list. It is instantiated once.
- The FIFO, issue logic, accumulator and result register are inline in `alu_cmd_sequencer`.

## Test plan
- ADD 0xF0+0x20, res_ready=1 → ALU_OUT=0x10, Cout=1, C_Flag=0, res_valid one cycle after the accept edge.
- SUB 0x05−0x07 → 0xFE, Cout=0; then SUB 0x07−0x05 → 0x02, Cout=1, back-to-back on consecutive cycles.
- CMP 0x80 vs 0x7F → ALU_OUT=0x00, C_Flag=1; CMP 0x33 vs 0x33 → C_Flag=0; SHLA 0x81 → 0x02, Cout=1.
- res_ready=0, drive 6 commands → 5 accepted, cmd_ready=0 with level=4. Then res_ready toggles 1/0 → all 5 results emerge in order, none lost or duplicated, and the 6th is then accepted.
- Chain: ADD 0x01+0x02, then ADD use_acc B=0x04 → 0x07, then SHLA use_acc → 0x0E, with no gap cycles.
- 3 commands queued and a result pending, RST low mid-cycle → all outputs are 0 immediately. After release, level=0 and res_valid stays 0.
